spi_frame_ctrl: RTL and testbench

//  Clock-domain controller that sequences the SPI slave shift register on the FPGA.

---
 rtl/spi_ctrl_pkg.sv | 29 ++
 rtl/sck_sync_edge.sv | 43 ++++
 rtl/spi_frame_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_spi_frame_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI frame controller.
//   spi_state_t : frame sequencer states
//   spi_word_t  : one 32-bit SPI frame payload
//   cursor_t    : received word split into cursor x (upper half) / y (lower half)
package spi_ctrl_pkg;

    localparam int unsigned FRAME_BITS = 32;
    localparam int unsigned HALF_BITS  = FRAME_BITS / 2;

    typedef enum logic [1:0] {
        RESYNC = 2'd0,
        LOAD   = 2'd1,
        SHIFT  = 2'd2,
        DONE   = 2'd3
    } spi_state_t;

    typedef logic [FRAME_BITS-1:0] spi_word_t;

    typedef struct packed {
        logic [HALF_BITS-1:0] x;
        logic [HALF_BITS-1:0] y;
    } cursor_t;

    // Upper half of the frame is x, lower half is y.
    function automatic cursor_t split_word(input spi_word_t w);
        return cursor_t'(w);
    endfunction

endpackage

// File: rtl/sck_sync_edge.sv
// Synchronizes the raw SPI clock into clk and produces registered
// single-cycle rise/fall pulses.
// Ports:
//   clk    in  system clock
//   reset  in  synchronous active-high reset
//   sck_i  in  raw sck, asynchronous to clk
//   rise_o out 1-cycle pulse per synchronized rising edge
//   fall_o out 1-cycle pulse per synchronized falling edge
// Pulse latency from an sck transition is SYNC_STAGES+1 clk cycles.
module sck_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic sck_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise_q;
    logic                   fall_q;

    // Metastability chain, previous-value flop and registered edge pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sck_i};
            prev_q <= sync_q[SYNC_STAGES-1];
            rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
            fall_q <= ~sync_q[SYNC_STAGES-1] & prev_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/spi_frame_ctrl.sv
// Clock-domain sequencer for the SPI slave shift register: counts 32-bit
// frames from the synchronized sck, captures each received word as cursor
// x/y, and round-robin picks the next outgoing word among NREQ requesters.
// Ports:
//   clk, reset  system clock, synchronous active-high reset
//   sck_in      raw SPI clock from the master
//   spi_q       received word from the slave (sampled at frame end)
//   spi_d       word the slave loads at the start of the next frame
//   spi_reset   reset to the slave's bit counter
//   req         per-requester pending flag, held until its grant
//   req_data    requester words, slice i = [32*i+31:32*i]
//   grant       1-cycle pulse when that requester's word completed a frame
//   rx_valid    1-cycle pulse, new rx_x/rx_y available
//   rx_x, rx_y  upper / lower half of the last completed received word
//   frame_err   1-cycle pulse when a stalled frame is aborted
//   busy        high while the bit count is non-zero
module spi_frame_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int unsigned NREQ        = 2,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 1024,
    parameter int unsigned RST_CYCLES  = 4,
    parameter spi_word_t   IDLE_WORD   = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sck_in,
    input  logic [31:0]          spi_q,
    output logic [31:0]          spi_d,
    output logic                 spi_reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*32-1:0]   req_data,
    output logic [NREQ-1:0]      grant,
    output logic                 rx_valid,
    output logic [15:0]          rx_x,
    output logic [15:0]          rx_y,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CNT_W = $clog2(FRAME_BITS + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    localparam int unsigned RST_W = $clog2(RST_CYCLES + 1);

    logic             sck_rise;
    logic             sck_fall;

    spi_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [TMO_W-1:0] tmo_q;
    logic [RST_W-1:0] rst_cnt_q;
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] sel_q;
    logic             sel_vld_q;
    logic             pend_fall_q;

    spi_word_t        spi_d_q;
    logic             spi_reset_q;
    logic [NREQ-1:0]  grant_q;
    logic             rx_valid_q;
    cursor_t          rx_q;
    logic             frame_err_q;
    logic             busy_q;

    logic             pick_vld;
    logic [PTR_W-1:0] pick_idx;
    spi_word_t        pick_word;
    int unsigned      scan;

    sck_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sck_sync (
        .clk    (clk),
        .reset  (reset),
        .sck_i  (sck_in),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    // Round-robin pick: first pending requester scanning upward from ptr with wrap.
    always_comb begin
        pick_vld  = 1'b0;
        pick_idx  = '0;
        pick_word = IDLE_WORD;
        scan      = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan = (32'(ptr_q) + k) % NREQ;
            if (!pick_vld && req[PTR_W'(scan)]) begin
                pick_vld  = 1'b1;
                pick_idx  = PTR_W'(scan);
                pick_word = req_data[scan*FRAME_BITS +: FRAME_BITS];
            end
        end
    end

    // Frame sequencer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RESYNC;
            cnt_q       <= '0;
            tmo_q       <= '0;
            rst_cnt_q   <= '0;
            ptr_q       <= '0;
            sel_q       <= '0;
            sel_vld_q   <= 1'b0;
            pend_fall_q <= 1'b0;
            spi_d_q     <= IDLE_WORD;
            spi_reset_q <= 1'b1;
            grant_q     <= '0;
            rx_valid_q  <= 1'b0;
            rx_q        <= '0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            grant_q     <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;

            unique case (state_q)
                // Hold the slave in reset; sck edges are discarded here.
                RESYNC: begin
                    cnt_q       <= '0;
                    busy_q      <= 1'b0;
                    tmo_q       <= '0;
                    pend_fall_q <= 1'b0;
                    if (rst_cnt_q == RST_W'(RST_CYCLES - 1)) begin
                        rst_cnt_q   <= '0;
                        spi_reset_q <= 1'b0;
                        state_q     <= LOAD;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + RST_W'(1);
                    end
                end

                // Latch the outgoing word; it stays put for the whole next frame.
                LOAD: begin
                    spi_d_q   <= pick_vld ? pick_word : IDLE_WORD;
                    sel_q     <= pick_idx;
                    sel_vld_q <= pick_vld;
                    tmo_q     <= '0;
                    if (sck_fall) begin
                        pend_fall_q <= 1'b1;
                    end
                    state_q <= SHIFT;
                end

                // Count falls; a fall seen during LOAD/DONE is replayed via pend_fall_q.
                SHIFT: begin
                    if (sck_fall || pend_fall_q) begin
                        pend_fall_q <= 1'b0;
                        tmo_q       <= '0;
                        cnt_q       <= cnt_q + CNT_W'(1);
                        busy_q      <= 1'b1;
                        if (cnt_q == CNT_W'(FRAME_BITS - 1)) begin
                            state_q <= DONE;
                        end
                    end else if (sck_rise) begin
                        tmo_q <= '0;
                    end else if (cnt_q != '0) begin
                        // Stalled mid-frame: abort without grant and leave ptr alone.
                        if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                            frame_err_q <= 1'b1;
                            spi_reset_q <= 1'b1;
                            rst_cnt_q   <= '0;
                            cnt_q       <= '0;
                            busy_q      <= 1'b0;
                            tmo_q       <= '0;
                            state_q     <= RESYNC;
                        end else begin
                            tmo_q <= tmo_q + TMO_W'(1);
                        end
                    end
                end

                // Publish the received word and retire the granted requester.
                DONE: begin
                    rx_q       <= split_word(spi_q);
                    rx_valid_q <= 1'b1;
                    cnt_q      <= '0;
                    busy_q     <= 1'b0;
                    if (sel_vld_q) begin
                        grant_q[sel_q] <= 1'b1;
                        if (sel_q == PTR_W'(NREQ - 1)) begin
                            ptr_q <= '0;
                        end else begin
                            ptr_q <= sel_q + PTR_W'(1);
                        end
                    end
                    if (sck_fall) begin
                        pend_fall_q <= 1'b1;
                    end
                    state_q <= LOAD;
                end

                default: state_q <= RESYNC;
            endcase
        end
    end

    assign spi_d     = spi_d_q;
    assign spi_reset = spi_reset_q;
    assign grant     = grant_q;
    assign rx_valid  = rx_valid_q;
    assign rx_x      = rx_q.x;
    assign rx_y      = rx_q.y;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Self-checking bench for spi_frame_ctrl: directed scenarios followed by
// random requester traffic, scored against a frame-level arbitration model.
module tb_spi_frame_ctrl;

    localparam int unsigned NREQ      = 2;
    localparam int unsigned SYNC      = 2;
    localparam int unsigned TIMEOUT   = 1024;
    localparam int unsigned RSTC      = 4;
    localparam logic [31:0] IDLE      = 32'h0000_0000;
    localparam int          HALF      = 4;   // sck half period in clk cycles
    localparam int          GAP       = 10;  // inter-frame gap in clk cycles
    localparam logic [31:0] WORD_A    = 32'h0000_000A;
    localparam logic [31:0] WORD_B    = 32'h0000_000B;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 sck_in;
    logic [31:0]          spi_q;
    logic [31:0]          spi_d;
    logic                 spi_reset;
    logic [NREQ-1:0]      req;
    logic [NREQ*32-1:0]   req_data;
    logic [NREQ-1:0]      grant;
    logic                 rx_valid;
    logic [15:0]          rx_x;
    logic [15:0]          rx_y;
    logic                 frame_err;
    logic                 busy;

    int n_checks = 0;
    int n_errors = 0;
    int n_rx = 0;
    int n_gr = 0;
    int n_fe = 0;

    // Model state
    int          m_ptr;
    logic [15:0] m_rx_x;
    logic [15:0] m_rx_y;
    int          exp_w;
    bit          exp_v;
    logic [31:0] exp_word;
    logic [31:0] exp_q;
    logic [NREQ-1:0] g_last;
    logic [31:0] word_last;

    spi_frame_ctrl #(
        .NREQ        (NREQ),
        .SYNC_STAGES (SYNC),
        .TIMEOUT     (TIMEOUT),
        .RST_CYCLES  (RSTC),
        .IDLE_WORD   (IDLE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sck_in    (sck_in),
        .spi_q     (spi_q),
        .spi_d     (spi_d),
        .spi_reset (spi_reset),
        .req       (req),
        .req_data  (req_data),
        .grant     (grant),
        .rx_valid  (rx_valid),
        .rx_x      (rx_x),
        .rx_y      (rx_y),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled away from the active edge.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) n_rx++;
        if (grant !== '0 && !$isunknown(grant)) n_gr++;
        if (frame_err === 1'b1) n_fe++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Frame-level model: the next word is the first pending requester at or after ptr.
    function automatic void compute_exp();
        exp_v    = 1'b0;
        exp_w    = 0;
        exp_word = IDLE;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NREQ;
            if (!exp_v && req[idx]) begin
                exp_v    = 1'b1;
                exp_w    = idx;
                exp_word = req_data[idx*32 +: 32];
            end
        end
        exp_q = spi_q;
    endfunction

    task automatic apply_stim(input bit dir, input logic [NREQ-1:0] nreq,
                              input logic [NREQ*32-1:0] ndata, input logic [31:0] nq,
                              input bit was_v, input int was_w);
        if (dir) begin
            req      = nreq;
            req_data = ndata;
            spi_q    = nq;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && !(was_v && was_w == i)) begin
                    // still waiting for its grant: keep request and word
                end else if ($urandom_range(0, 3) != 0) begin
                    req[i] = 1'b1;
                    req_data[i*32 +: 32] = $urandom;
                end else begin
                    req[i] = 1'b0;
                end
            end
            spi_q = $urandom;
        end
        compute_exp();
    endtask

    task automatic drive_bits(input int n, input bit last);
        for (int b = 0; b < n; b++) begin
            sck_in = 1'b1;
            repeat (HALF) @(negedge clk);
            sck_in = 1'b0;
            if (!(last && b == n - 1)) repeat (HALF) @(negedge clk);
        end
    endtask

    task automatic count_spi_reset(input string tag);
        int hi;
        hi = 0;
        for (int k = 0; k < 50; k++) begin
            if (spi_reset === 1'b1) hi++;
            else break;
            @(negedge clk);
        end
        check_eq(tag, hi, RSTC);
    endtask

    // One full frame, then set up the following frame's stimulus at the rx_valid cycle.
    task automatic run_frame(input bit dir, input logic [NREQ-1:0] nreq,
                             input logic [NREQ*32-1:0] ndata, input logic [31:0] nq);
        int rx0, gr0, fe0;
        bit seen;
        bit cur_v;
        int cur_w;
        repeat (GAP) @(negedge clk);
        check_eq("spi_d_load", spi_d, exp_word);
        check_eq("busy_idle", 32'(busy), 32'd0);
        check_eq("rx_x_hold", 32'(rx_x), 32'(m_rx_x));
        check_eq("rx_y_hold", 32'(rx_y), 32'(m_rx_y));
        rx0 = n_rx; gr0 = n_gr; fe0 = n_fe;
        cur_v = exp_v; cur_w = exp_w;
        word_last = exp_word;
        drive_bits(16, 1'b0);
        check_eq("busy_mid", 32'(busy), 32'd1);
        check_eq("spi_d_mid", spi_d, exp_word);
        drive_bits(16, 1'b1);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (rx_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("rx_valid_seen", 32'(seen), 32'd1);
        g_last = grant;
        if (seen) begin
            check_eq("rx_x", 32'(rx_x), 32'(exp_q[31:16]));
            check_eq("rx_y", 32'(rx_y), 32'(exp_q[15:0]));
            check_eq("grant", 32'(grant), cur_v ? (32'd1 << cur_w) : 32'd0);
        end
        m_rx_x = exp_q[31:16];
        m_rx_y = exp_q[15:0];
        if (cur_v) m_ptr = (cur_w + 1) % NREQ;
        apply_stim(dir, nreq, ndata, nq, cur_v, cur_w);
        repeat (3) @(negedge clk);
        check_eq("rx_valid_count", 32'(n_rx - rx0), 32'd1);
        check_eq("grant_count", 32'(n_gr - gr0), cur_v ? 32'd1 : 32'd0);
        check_eq("frame_err_none", 32'(n_fe - fe0), 32'd0);
    endtask

    initial begin
        logic [1:0] g_exp [4];
        g_exp = '{2'b01, 2'b10, 2'b01, 2'b10};

        // Reset and power-up resync
        reset    = 1'b1;
        sck_in   = 1'b0;
        req      = '0;
        req_data = '0;
        spi_q    = $urandom;
        m_ptr    = 0;
        m_rx_x   = '0;
        m_rx_y   = '0;
        compute_exp();
        repeat (3) @(negedge clk);
        check_eq("rst_spi_d", spi_d, IDLE);
        check_eq("rst_spi_reset", 32'(spi_reset), 32'd1);
        check_eq("rst_outputs", {grant, rx_valid, frame_err, busy}, '0);
        check_eq("rst_rx", {rx_x, rx_y}, 32'd0);
        reset = 1'b0;
        count_spi_reset("spi_reset_cycles");
        check_eq("no_pulses_after_reset", 32'(n_rx + n_gr + n_fe), 32'd0);

        // Idle frame (no requesters), then DEADBEEF from requester 0
        run_frame(1'b1, 2'b01, {32'h5555_AAAA, 32'hDEAD_BEEF}, 32'h0123_0456);
        check_eq("idle_frame_word", word_last, IDLE);
        check_eq("idle_frame_grant", 32'(g_last), 32'd0);
        run_frame(1'b1, 2'b10, {32'h1357_9BDF, 32'h0}, $urandom);
        check_eq("t2_word", word_last, 32'hDEAD_BEEF);
        check_eq("t2_grant", 32'(g_last), 32'd1);
        check_eq("t2_rx_x", 32'(rx_x), 32'h0123);
        check_eq("t2_rx_y", 32'(rx_y), 32'h0456);
        run_frame(1'b1, 2'b11, {WORD_B, WORD_A}, $urandom);

        // Both requesting: alternate A, B, A, B
        for (int i = 0; i < 4; i++) begin
            run_frame(1'b1, 2'b11, {WORD_B, WORD_A}, $urandom);
            check_eq("t3_grant", 32'(g_last), 32'(g_exp[i]));
            check_eq("t3_word", word_last, (i % 2 == 1) ? WORD_B : WORD_A);
        end

        // Stalled frame after 10 bits: abort, then the same word is re-offered
        begin
            int rx0, gr0, fe0;
            bit seen;
            repeat (GAP) @(negedge clk);
            check_eq("abort_spi_d", spi_d, WORD_A);
            rx0 = n_rx; gr0 = n_gr; fe0 = n_fe;
            drive_bits(10, 1'b0);
            seen = 1'b0;
            for (int k = 0; k < TIMEOUT + 200; k++) begin
                @(negedge clk);
                if (frame_err === 1'b1) begin
                    seen = 1'b1;
                    break;
                end
            end
            check_eq("abort_frame_err", 32'(seen), 32'd1);
            check_eq("abort_grant", 32'(grant), 32'd0);
            @(negedge clk);
            check_eq("abort_spi_reset", 32'(spi_reset), 32'd1);
            check_eq("abort_busy", 32'(busy), 32'd0);
            check_eq("abort_no_rx", 32'(n_rx - rx0), 32'd0);
            check_eq("abort_no_grant", 32'(n_gr - gr0), 32'd0);
            check_eq("abort_fe_count", 32'(n_fe - fe0), 32'd1);
            compute_exp();
        end
        run_frame(1'b0, '0, '0, '0);
        check_eq("abort_reoffer_word", word_last, WORD_A);
        check_eq("abort_reoffer_grant", 32'(g_last), 32'd1);

        // Reset at bit 20: no completion, then a normal frame
        begin
            int rx0, gr0;
            repeat (GAP) @(negedge clk);
            rx0 = n_rx; gr0 = n_gr;
            drive_bits(20, 1'b0);
            reset = 1'b1;
            repeat (2) @(negedge clk);
            reset = 1'b0;
            count_spi_reset("midreset_spi_reset_cycles");
            check_eq("midreset_no_rx", 32'(n_rx - rx0), 32'd0);
            check_eq("midreset_no_grant", 32'(n_gr - gr0), 32'd0);
            check_eq("midreset_busy", 32'(busy), 32'd0);
            m_ptr  = 0;
            m_rx_x = '0;
            m_rx_y = '0;
            compute_exp();
        end

        // Random requester traffic
        for (int i = 0; i < 12; i++) begin
            run_frame(1'b0, '0, '0, '0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
